gray_stream_packer: RTL and testbench

//  Downstream of the RGB->gray converter inside the grayscale accelerator.
//  - Accepts one 8-bit gray pixel per cycle over a valid/ready handshake.
//  - Packs 4 pixels into each 32-bit AXI4-Stream master beat.
//  - Flushes a partial word at end of frame, with TKEEP marking valid bytes.

---
 rtl/gray_stream_packer.sv | 135 +++++++++++++
 tb/tb_gray_stream_packer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_packer.sv
// Packs 8-bit gray pixels four at a time into 32-bit AXI4-Stream beats.
// A frame's partial trailing word is flushed on gray_last, and TKEEP marks its valid bytes.
module gray_stream_packer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 m00_axis_aclk,
    input  logic                 m00_axis_aresetn,
    input  logic [7:0]           gray_in,
    input  logic                 gray_valid,
    input  logic                 gray_last,
    output logic                 gray_ready,
    output logic [31:0]          m00_axis_tdata,
    output logic [3:0]           m00_axis_tkeep,
    output logic                 m00_axis_tlast,
    output logic                 m00_axis_tvalid,
    input  logic                 m00_axis_tready,
    output logic [CNT_WIDTH-1:0] frame_words,
    output logic                 frame_done
);

    logic [1:0]           idx_q, idx_d;
    logic [23:0]          acc_q, acc_d;
    logic [31:0]          tdata_q, tdata_d;
    logic [3:0]           tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic                 tvalid_q, tvalid_d;
    logic [CNT_WIDTH-1:0] frame_words_q, frame_words_d;
    logic                 frame_done_q, frame_done_d;
    logic                 restart_q, restart_d;
    logic                 acc_fire_s, out_fire_s, load_s;
    logic [31:0]          word_s;
    logic [3:0]           keep_s;

    assign gray_ready = !tvalid_q || m00_axis_tready;
    assign acc_fire_s = gray_valid && gray_ready;
    assign out_fire_s = tvalid_q && m00_axis_tready;
    assign load_s     = acc_fire_s && ((idx_q == 2'd3) || gray_last);

    // Next-state logic for the accumulator, the output beat register and the frame counter
    always_comb begin
        idx_d         = idx_q;
        acc_d         = acc_q;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;
        frame_words_d = frame_words_q;
        frame_done_d  = 1'b0;
        restart_d     = restart_q;

        // Bytes of acc at and above idx are always zero, so padding comes for free.
        word_s = {8'd0, acc_q};
        case (idx_q)
            2'd0:    begin word_s[7:0]   = gray_in; keep_s = 4'b0001; end
            2'd1:    begin word_s[15:8]  = gray_in; keep_s = 4'b0011; end
            2'd2:    begin word_s[23:16] = gray_in; keep_s = 4'b0111; end
            2'd3:    begin word_s[31:24] = gray_in; keep_s = 4'b1111; end
            default: begin word_s = 32'd0;          keep_s = 4'b0000; end
        endcase

        if (load_s) begin
            tdata_d  = word_s;
            tkeep_d  = keep_s;
            tlast_d  = gray_last;
            tvalid_d = 1'b1;
            idx_d    = 2'd0;
            acc_d    = 24'd0;
        end else if (acc_fire_s) begin
            case (idx_q)
                2'd0:    acc_d[7:0]   = gray_in;
                2'd1:    acc_d[15:8]  = gray_in;
                2'd2:    acc_d[23:16] = gray_in;
                default: acc_d        = acc_q;
            endcase
            idx_d = idx_q + 2'd1;
            if (out_fire_s) begin
                tvalid_d = 1'b0;
            end else begin
                tvalid_d = tvalid_q;
            end
        end else if (out_fire_s) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        // Count holds after TLAST so software can read it; the next beat restarts it at 1.
        if (out_fire_s) begin
            if (restart_q) begin
                frame_words_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (frame_words_q != {CNT_WIDTH{1'b1}}) begin
                frame_words_d = frame_words_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                frame_words_d = frame_words_q;
            end
            frame_done_d = tlast_q;
            restart_d    = tlast_q;
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            idx_q         <= 2'd0;
            acc_q         <= 24'd0;
            tdata_q       <= 32'd0;
            tkeep_q       <= 4'd0;
            tlast_q       <= 1'b0;
            tvalid_q      <= 1'b0;
            frame_words_q <= {CNT_WIDTH{1'b0}};
            frame_done_q  <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
            tlast_q       <= tlast_d;
            tvalid_q      <= tvalid_d;
            frame_words_q <= frame_words_d;
            frame_done_q  <= frame_done_d;
            restart_q     <= restart_d;
        end
    end

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tkeep  = tkeep_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tvalid = tvalid_q;
    assign frame_words     = frame_words_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_gray_stream_packer.sv
// Directed self-checking bench for gray_stream_packer with hand-computed expected beats.
module tb_gray_stream_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  gray_in;
    logic        gray_valid;
    logic        gray_last;
    logic        gray_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic [15:0] frame_words;
    logic        frame_done;

    int tests_run = 0;
    int tests_failed = 0;

    gray_stream_packer #(.CNT_WIDTH(16)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .gray_in          (gray_in),
        .gray_valid       (gray_valid),
        .gray_last        (gray_last),
        .gray_ready       (gray_ready),
        .m00_axis_tdata   (tdata),
        .m00_axis_tkeep   (tkeep),
        .m00_axis_tlast   (tlast),
        .m00_axis_tvalid  (tvalid),
        .m00_axis_tready  (tready),
        .frame_words      (frame_words),
        .frame_done       (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                              input logic l);
        check_eq({tag, "_tvalid"}, {31'd0, tvalid}, 32'd1);
        check_eq({tag, "_tdata"}, tdata, d);
        check_eq({tag, "_tkeep"}, {28'd0, tkeep}, {28'd0, k});
        check_eq({tag, "_tlast"}, {31'd0, tlast}, {31'd0, l});
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        gray_in    = d;
        gray_valid = 1'b1;
        gray_last  = l;
        @(posedge clk);
        #1;
        gray_valid = 1'b0;
        gray_last  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        gray_valid = 1'b0;
        gray_last  = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_eq({tag, "_rst_tvalid"}, {31'd0, tvalid}, 32'd0);
        check_eq({tag, "_rst_tdata"}, tdata, 32'd0);
        check_eq({tag, "_rst_tkeep"}, {28'd0, tkeep}, 32'd0);
        check_eq({tag, "_rst_tlast"}, {31'd0, tlast}, 32'd0);
        check_eq({tag, "_rst_fwords"}, {16'd0, frame_words}, 32'd0);
        check_eq({tag, "_rst_fdone"}, {31'd0, frame_done}, 32'd0);
        check_eq({tag, "_rst_ready"}, {31'd0, gray_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b1;
        tready     = 1'b1;
        gray_in    = 8'd0;
        gray_valid = 1'b0;
        gray_last  = 1'b0;
        #2;
        do_reset("init");

        // Four pixels make one full beat, one cycle after the 4th pixel
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        check_eq("t1_no_beat_yet", {31'd0, tvalid}, 32'd0);
        push(8'h44, 1'b0);
        check_beat("t1_beat", 32'h44332211, 4'hF, 1'b0);
        idle();
        check_eq("t1_drained", {31'd0, tvalid}, 32'd0);
        check_eq("t1_fwords", {16'd0, frame_words}, 32'd1);

        // Six pixels: full beat then 2-byte flushed tail
        do_reset("t2");
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        check_beat("t2_beat0", 32'h44332211, 4'hF, 1'b0);
        push(8'h55, 1'b0);
        check_eq("t2_gap", {31'd0, tvalid}, 32'd0);
        check_eq("t2_fwords1", {16'd0, frame_words}, 32'd1);
        push(8'h66, 1'b1);
        check_beat("t2_beat1", 32'h00006655, 4'h3, 1'b1);
        idle();
        check_eq("t2_fdone", {31'd0, frame_done}, 32'd1);
        check_eq("t2_fwords2", {16'd0, frame_words}, 32'd2);
        check_eq("t2_drained", {31'd0, tvalid}, 32'd0);
        idle();
        check_eq("t2_fdone_pulse", {31'd0, frame_done}, 32'd0);
        check_eq("t2_fwords_hold", {16'd0, frame_words}, 32'd2);

        // Continuous eight pixels: ready never drops, count restarts after TLAST
        for (int i = 1; i <= 8; i++) begin
            check_eq("t3_ready", {31'd0, gray_ready}, 32'd1);
            push(i[7:0], 1'b0);
            if (i == 4) check_beat("t3_beat0", 32'h04030201, 4'hF, 1'b0);
            if (i == 5) check_eq("t3_fwords_restart", {16'd0, frame_words}, 32'd1);
            if (i == 8) check_beat("t3_beat1", 32'h08070605, 4'hF, 1'b0);
        end
        idle();
        check_eq("t3_fwords", {16'd0, frame_words}, 32'd2);

        // Backpressure: beat held stable, pixel 0D not absorbed
        push(8'h09, 1'b0);
        push(8'h0A, 1'b0);
        push(8'h0B, 1'b0);
        push(8'h0C, 1'b0);
        check_beat("t4_beat", 32'h0C0B0A09, 4'hF, 1'b0);
        tready     = 1'b0;
        gray_in    = 8'h0D;
        gray_valid = 1'b1;
        #1;
        check_eq("t4_ready_low", {31'd0, gray_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            idle();
            check_beat("t4_stall", 32'h0C0B0A09, 4'hF, 1'b0);
            check_eq("t4_stall_ready", {31'd0, gray_ready}, 32'd0);
            check_eq("t4_stall_fwords", {16'd0, frame_words}, 32'd2);
        end
        tready = 1'b1;
        idle();
        gray_valid = 1'b0;
        check_eq("t4_release_fwords", {16'd0, frame_words}, 32'd3);
        check_eq("t4_release_tvalid", {31'd0, tvalid}, 32'd0);
        push(8'h0E, 1'b0);
        push(8'h0F, 1'b0);
        push(8'h10, 1'b0);
        check_beat("t4_resume", 32'h100F0E0D, 4'hF, 1'b0);
        idle();
        check_eq("t4_fwords", {16'd0, frame_words}, 32'd4);

        // Single-pixel frames back to back: new word replaces old with no bubble
        push(8'hA5, 1'b1);
        check_beat("t5_single", 32'h000000A5, 4'h1, 1'b1);
        push(8'hB6, 1'b1);
        check_beat("t5_replace", 32'h000000B6, 4'h1, 1'b1);
        check_eq("t5_fdone0", {31'd0, frame_done}, 32'd1);
        check_eq("t5_fwords0", {16'd0, frame_words}, 32'd5);
        idle();
        check_eq("t5_fdone1", {31'd0, frame_done}, 32'd1);
        check_eq("t5_fwords1", {16'd0, frame_words}, 32'd1);
        check_eq("t5_drained", {31'd0, tvalid}, 32'd0);
        idle();
        check_eq("t5_fdone_end", {31'd0, frame_done}, 32'd0);

        // Reset discards partial word and pending beat
        push(8'hD1, 1'b0);
        push(8'hD2, 1'b0);
        do_reset("t6a");
        push(8'hE1, 1'b0);
        push(8'hE2, 1'b0);
        push(8'hE3, 1'b0);
        push(8'hE4, 1'b0);
        check_beat("t6_fresh", 32'hE4E3E2E1, 4'hF, 1'b0);
        idle();
        check_eq("t6_fwords", {16'd0, frame_words}, 32'd1);
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hC4, 1'b0);
        tready = 1'b0;
        idle();
        check_beat("t6_pending", 32'hC4C3C2C1, 4'hF, 1'b0);
        do_reset("t6b");
        tready = 1'b1;
        idle();
        check_eq("t6_post_tvalid", {31'd0, tvalid}, 32'd0);
        check_eq("t6_post_fwords", {16'd0, frame_words}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
